fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC and drives the instruction-memory request/ready handshake.
- Delivers one instruction per accepted fetch to the IF/ID pipeline register as Instruction_F / NPC_F, plus that register's kill and hold controls.
- Absorbs variable instruction-memory latency, load-use stalls and branch/jump redirects. Stale responses are never delivered.

Parameters:
- RESET_PC, 32'h00000000, PC value after reset.
- NOP_INSTR, 32'h00000000, value driven on Instruction_F when no valid instruction is delivered.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold PC and IF/ID this cycle
- redirect  input  1  taken branch/jump resolved downstream; current fetch is wrong-path
- redirect_pc  input  32  target PC, valid when redirect=1
- imem_req  output  1  instruction-memory request
- imem_addr  output  32  request address; word aligned
- imem_ready  input  1  memory completes the current request this cycle
- imem_rdata  input  32  instruction; valid only when imem_ready=1
- Instruction_F  output  32  instruction to IF/ID
- NPC_F  output  32  address of the delivered instruction + 4
- fetch_valid  output  1  Instruction_F/NPC_F are valid this cycle
- kill_F  output  1  to IF/ID kill; equals ~fetch_valid
- disable_IR_F  output  1  to IF/ID disable_IR; equals stall

Behaviour:
- Registers:
  - pc (next fetch address).
  - req_addr (address of the outstanding request).
  - ibuf (32-bit held instruction).
  - state ∈ {FETCH, HOLD, FLUSH}.
- Reset (sync, dominates everything):
  - pc=RESET_PC, req_addr=RESET_PC, ibuf=NOP_INSTR, state=FETCH.
  - While reset=1: imem_req=0, fetch_valid=0, Instruction_F=NOP_INSTR, NPC_F=0.
  - The first request issues in the cycle after reset deasserts.
- Handshake rules:
  - imem_req held high with imem_addr stable until imem_ready=1.
  - Data is sampled combinationally in the ready cycle; there is at most one outstanding request.
  - Zero-wait memory (ready in the same cycle as req) sustains 1 instruction/cycle.
- Event priority within a cycle: reset > redirect > stall > normal.
- FETCH: imem_req=1, imem_addr=pc, req_addr<=pc.
  - redirect=1: fetch_valid=0; pc<=redirect_pc.
    - If imem_ready=1: stay FETCH (response discarded).
    - Else: req_addr holds the old address and state goes to FLUSH.
  - imem_ready=1 & stall=1: ibuf<=imem_rdata, go to HOLD, fetch_valid=0, pc unchanged.
  - imem_ready=1 & stall=0: fetch_valid=1, Instruction_F=imem_rdata, NPC_F=pc+4, pc<=pc+4, stay FETCH.
  - imem_ready=0: fetch_valid=0, stay FETCH.
- HOLD: imem_req=0.
  - redirect=1: discard ibuf, pc<=redirect_pc, go to FETCH, fetch_valid=0.
  - stall=1: fetch_valid=0, stay HOLD.
  - stall=0: fetch_valid=1, Instruction_F=ibuf, NPC_F=pc+4, pc<=pc+4, go to FETCH.
- FLUSH: imem_req=1, imem_addr=req_addr (stale request kept stable), fetch_valid=0 always.
  - imem_ready=1: go to FETCH; data dropped.
  - redirect=1: pc<=redirect_pc (last redirect wins). If imem_ready is also 1, go to FETCH.
- Outputs:
  - When fetch_valid=0: Instruction_F=NOP_INSTR, NPC_F=0.
  - kill_F = ~fetch_valid, so IF/ID loads a NOP on bubbles. When stall=1, disable_IR_F=1 takes precedence at IF/ID.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
- redirect_pc is used as given; bits [1:0] are not checked.
- A single delivered instruction is never issued twice and never skipped. A wrong-path instruction is never valid.

Test Plan:
- Reset then zero-wait memory returning rdata=addr|32'hA0000000 → fetch_valid=1 on consecutive cycles: imem_addr 0,4,8; NPC_F 4,8,12.
- Memory ready 2 cycles after req at addr 0x10 → imem_addr stays 0x10 for 3 cycles, fetch_valid=1 only in the ready cycle, NPC_F=0x14.
- stall=1 for 3 cycles coinciding with ready at 0x20 → imem_req=0 and fetch_valid=0 during stall. On release, Instruction_F=ibuf and NPC_F=0x24 with no re-request of 0x20.
- redirect to 0x100 while request at 0x40 is pending (ready 2 cycles later) → FLUSH keeps addr 0x40 until ready, 0x40 data never valid, next request at 0x100.
- redirect to 0x200 in the same cycle as ready+stall=0 at 0x30 → fetch_valid=0, kill_F=1, next imem_addr=0x200. Then reset asserted mid-wait → next imem_addr=RESET_PC.
- pc=32'hFFFFFFFC with zero-wait memory → NPC_F=0, next imem_addr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake
// and hands one instruction per accepted fetch to the IF/ID register.
//
// state | meaning
// FETCH | request at pc outstanding; deliver, capture or drop on ready
// HOLD  | instruction captured in ibuf while stalled; no request
// FLUSH | wrong-path request still outstanding; held stable and dropped on ready
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_F,
  output logic [31:0] NPC_F,
  output logic        fetch_valid,
  output logic        kill_F,
  output logic        disable_IR_F
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    ibuf_d        = ibuf_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;
    fetch_valid   = 1'b0;
    Instruction_F = NOP_INSTR;
    NPC_F         = 32'h0;

    if (!reset) begin
      case (state_q)
        FETCH: begin
          imem_req   = 1'b1;
          imem_addr  = pc_q;
          req_addr_d = pc_q;
          if (redirect) begin
            pc_d = redirect_pc;
            if (!imem_ready) state_d = FLUSH;
          end else if (imem_ready) begin
            if (stall) begin
              ibuf_d  = imem_rdata;
              state_d = HOLD;
            end else begin
              fetch_valid   = 1'b1;
              Instruction_F = imem_rdata;
              NPC_F         = pc_plus4;
              pc_d          = pc_plus4;
            end
          end
        end

        HOLD: begin
          if (redirect) begin
            pc_d    = redirect_pc;
            ibuf_d  = NOP_INSTR;
            state_d = FETCH;
          end else if (!stall) begin
            fetch_valid   = 1'b1;
            Instruction_F = ibuf_q;
            NPC_F         = pc_plus4;
            pc_d          = pc_plus4;
            state_d       = FETCH;
          end
        end

        FLUSH: begin
          // The stale request must stay stable until memory completes it.
          imem_req  = 1'b1;
          imem_addr = req_addr_q;
          if (redirect)   pc_d    = redirect_pc;
          if (imem_ready) state_d = FETCH;
        end

        default: state_d = FETCH;
      endcase
    end
  end

  assign kill_F       = ~fetch_valid;
  assign disable_IR_F = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ibuf_q     <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ibuf_q     <= ibuf_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory responder, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] TAG  = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] Instruction_F, NPC_F;
  logic        fetch_valid, kill_F, disable_IR_F;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Instruction_F(Instruction_F), .NPC_F(NPC_F), .fetch_valid(fetch_valid),
    .kill_F(kill_F), .disable_IR_F(disable_IR_F)
  );

  // Memory: completes a request once it has been held for lat cycles.
  int lat = 0;
  int wcnt = 0;
  assign imem_ready = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr | TAG;
  always @(posedge clk) begin
    if (reset || !imem_req || imem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pc, an optional captured instruction, an optional stale request.
  logic [31:0] m_pc = RPC;
  logic [31:0] m_held_instr = NOP;
  logic [31:0] m_stale_addr = RPC;
  bit          m_held = 1'b0;
  bit          m_stale = 1'b0;
  logic        e_req, e_fv;
  logic [31:0] e_addr, e_instr, e_npc;

  always @(negedge clk) begin
    e_req = 1'b0; e_fv = 1'b0; e_addr = 32'h0; e_instr = NOP; e_npc = 32'h0;
    if (reset) begin
      m_pc = RPC; m_held = 1'b0; m_stale = 1'b0;
    end else if (m_held) begin
      if (redirect) begin
        m_held = 1'b0; m_pc = redirect_pc;
      end else if (!stall) begin
        e_fv = 1'b1; e_instr = m_held_instr; e_npc = m_pc + 32'd4;
        m_pc = m_pc + 32'd4; m_held = 1'b0;
      end
    end else if (m_stale) begin
      e_req = 1'b1; e_addr = m_stale_addr;
      if (redirect) m_pc = redirect_pc;
      if (imem_ready) m_stale = 1'b0;
    end else begin
      e_req = 1'b1; e_addr = m_pc;
      if (redirect) begin
        if (!imem_ready) begin m_stale = 1'b1; m_stale_addr = m_pc; end
        m_pc = redirect_pc;
      end else if (imem_ready) begin
        if (stall) begin
          m_held = 1'b1; m_held_instr = m_pc | TAG;
        end else begin
          e_fv = 1'b1; e_instr = m_pc | TAG; e_npc = m_pc + 32'd4;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    chk("model_req", {31'h0, imem_req}, {31'h0, e_req});
    if (e_req) chk("model_addr", imem_addr, e_addr);
    chk("model_valid", {31'h0, fetch_valid}, {31'h0, e_fv});
    chk("model_instr", Instruction_F, e_instr);
    chk("model_npc", NPC_F, e_npc);
    chk("model_kill", {31'h0, kill_F}, {31'h0, ~e_fv});
    chk("model_disable", {31'h0, disable_IR_F}, {31'h0, stall});
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic expect_fetch(input string nm, input logic [31:0] addr,
                              input logic fv, input logic [31:0] npc);
    @(negedge clk);
    chk({nm, "_req"}, {31'h0, imem_req}, 32'd1);
    chk({nm, "_addr"}, imem_addr, addr);
    chk({nm, "_valid"}, {31'h0, fetch_valid}, {31'h0, fv});
    if (fv) chk({nm, "_npc"}, NPC_F, npc);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_valid", {31'h0, fetch_valid}, 32'd0);
    chk("rst_instr", Instruction_F, NOP);
    chk("rst_npc", NPC_F, 32'h0);
    chk("rst_kill", {31'h0, kill_F}, 32'd1);
    nxt(); nxt(); reset = 1'b0;

    // zero-wait streaming
    expect_fetch("zw0", 32'h0, 1'b1, 32'h4);
    chk("zw0_instr", Instruction_F, 32'hA000_0000);
    nxt(); expect_fetch("zw1", 32'h4, 1'b1, 32'h8);
    nxt(); expect_fetch("zw2", 32'h8, 1'b1, 32'hC);
    nxt(); expect_fetch("zw3", 32'hC, 1'b1, 32'h10);

    // two wait states at 0x10
    nxt(); lat = 2; expect_fetch("ws0", 32'h10, 1'b0, 32'h0);
    nxt(); expect_fetch("ws1", 32'h10, 1'b0, 32'h0);
    nxt(); expect_fetch("ws2", 32'h10, 1'b1, 32'h14);

    // stall coinciding with ready at 0x20
    nxt(); lat = 0;
    nxt(); nxt();
    nxt(); stall = 1'b1; expect_fetch("st0", 32'h20, 1'b0, 32'h0);
    nxt(); @(negedge clk);
    chk("st1_req", {31'h0, imem_req}, 32'd0);
    chk("st1_valid", {31'h0, fetch_valid}, 32'd0);
    nxt(); @(negedge clk);
    chk("st2_req", {31'h0, imem_req}, 32'd0);
    nxt(); stall = 1'b0; @(negedge clk);
    chk("st_rel_req", {31'h0, imem_req}, 32'd0);
    chk("st_rel_valid", {31'h0, fetch_valid}, 32'd1);
    chk("st_rel_instr", Instruction_F, 32'hA000_0020);
    chk("st_rel_npc", NPC_F, 32'h24);
    nxt(); expect_fetch("st_after", 32'h24, 1'b1, 32'h28);

    // redirect while 0x40 pending
    repeat (6) nxt();
    nxt(); lat = 2; redirect = 1'b1; redirect_pc = 32'h100;
    expect_fetch("fl0", 32'h40, 1'b0, 32'h0);
    nxt(); redirect = 1'b0; expect_fetch("fl1", 32'h40, 1'b0, 32'h0);
    nxt(); expect_fetch("fl2", 32'h40, 1'b0, 32'h0);
    chk("fl2_ready", {31'h0, imem_ready}, 32'd1);
    nxt(); lat = 0; expect_fetch("fl_tgt", 32'h100, 1'b1, 32'h104);
    chk("fl_tgt_instr", Instruction_F, 32'hA000_0100);

    // redirect coinciding with ready at 0x30, then reset mid-wait
    nxt(); redirect = 1'b1; redirect_pc = 32'h30;
    expect_fetch("rd0", 32'h104, 1'b0, 32'h0);
    nxt(); redirect_pc = 32'h200; expect_fetch("rd1", 32'h30, 1'b0, 32'h0);
    chk("rd1_kill", {31'h0, kill_F}, 32'd1);
    nxt(); redirect = 1'b0; lat = 3; expect_fetch("rd2", 32'h200, 1'b0, 32'h0);
    nxt(); reset = 1'b1; @(negedge clk);
    chk("mrst_req", {31'h0, imem_req}, 32'd0);
    nxt(); reset = 1'b0; lat = 0; expect_fetch("mrst_pc", RPC, 1'b1, 32'h4);

    // wrap at top of address space
    nxt(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    expect_fetch("wr0", 32'h4, 1'b0, 32'h0);
    nxt(); redirect = 1'b0; expect_fetch("wr1", 32'hFFFF_FFFC, 1'b1, 32'h0);
    chk("wr1_instr", Instruction_F, 32'hFFFF_FFFC);
    nxt(); expect_fetch("wr2", 32'h0, 1'b1, 32'h4);

    // mixed stall/redirect/latency pattern, checked by the model
    for (int i = 0; i < 60; i++) begin
      nxt();
      stall       = (i % 5 == 2) || (i % 7 == 3);
      redirect    = (i % 11 == 6);
      redirect_pc = 32'h400 + 32'(i) * 32'd8;
      if (i % 8 == 0) lat = i % 3;
    end
    nxt(); stall = 1'b0; redirect = 1'b0; lat = 0;
    repeat (4) nxt();
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
